// File: rtl/demapper.sv
// Serial frame demapper: aligns on FAS, checks the pattern, and extracts payload bytes to the tx FIFO.
// Define DEMAP_BIP8_EN to add the trailing BIP-8 byte check (must match the mapper build).
module demapper #(
  parameter int unsigned PYLD_BYTES  = 16,
  parameter logic [15:0] FAS_PATTERN = 16'hF628,
  parameter int unsigned LOCK_LOSS   = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_frame_data,
  input  logic       i_frame_data_valid,
  input  logic       i_frame_data_fas,
  output logic [7:0] o_pyld_data,
  output logic       o_pyld_data_valid,
  input  logic       i_fifo_full,
  output logic       o_frame_lock,
  output logic       o_fas_err,
  output logic       o_len_err,
  output logic       o_ovf,
  output logic       o_bip_err
);

  localparam logic [11:0] PYLD_LAST = 12'(8 * PYLD_BYTES - 1);
  localparam logic [7:0]  PYLD_B8   = 8'(PYLD_BYTES);
  localparam logic [3:0]  LOSS4     = 4'(LOCK_LOSS);

  typedef enum logic [2:0] {ST_HUNT, ST_FAS, ST_LEN, ST_PYLD, ST_BIP} state_t;

`ifdef DEMAP_BIP8_EN
  localparam state_t AFTER_PYLD = ST_BIP;
`else
  localparam state_t AFTER_PYLD = ST_HUNT;
`endif

  state_t      r_state, w_state_next;
  logic [11:0] r_cnt, w_cnt_next;
  logic [15:0] r_sh;
  logic [7:0]  r_len, w_len_next;
  logic        r_sup, w_sup_next;
  logic [3:0]  r_miss, w_miss_next;
  logic        r_lock, w_lock_next;
  logic [7:0]  r_pyld_data, w_pyld_data_next;
  logic        r_pyld_valid, w_pyld_valid_next;
  logic        r_fas_err, w_fas_err_next;
  logic        r_len_err, w_len_err_next;
  logic        r_ovf, w_ovf_next;
`ifdef DEMAP_BIP8_EN
  logic [7:0]  r_bip, w_bip_next;
  logic        r_bip_err, w_bip_err_next;
`endif

  logic [15:0] w_sh_shift;
  logic [7:0]  w_byte;
  logic        w_byte_done, w_fas_last, w_pyld_last, w_fas_match, w_keep;
  logic [3:0]  w_miss_inc;
  logic        w_miss_hit;

  assign w_sh_shift  = {r_sh[14:0], i_frame_data};
  assign w_byte      = w_sh_shift[7:0];
  assign w_byte_done = (r_cnt[2:0] == 3'd7);
  assign w_fas_last  = (r_cnt == 12'd15);
  assign w_pyld_last = (r_cnt == PYLD_LAST);
  assign w_fas_match = (w_sh_shift == FAS_PATTERN);
  assign w_keep      = !r_sup && (r_cnt[11:3] < {1'b0, r_len});
  assign w_miss_inc  = (r_miss < LOSS4) ? r_miss + 4'd1 : r_miss;
  assign w_miss_hit  = (w_miss_inc == LOSS4);

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_HUNT;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (i_frame_data_valid) begin
      if (i_frame_data_fas) begin
        w_state_next = ST_FAS;
      end else begin
        case (r_state)
          ST_FAS:  if (w_fas_last) w_state_next = w_fas_match ? ST_LEN : ST_HUNT;
          ST_LEN:  if (w_byte_done) w_state_next = ST_PYLD;
          ST_PYLD: if (w_pyld_last) w_state_next = AFTER_PYLD;
`ifdef DEMAP_BIP8_EN
          ST_BIP:  if (w_byte_done) w_state_next = ST_HUNT;
`endif
          default: w_state_next = ST_HUNT;
        endcase
      end
    end
  end

  always_comb begin
    w_cnt_next        = r_cnt;
    w_len_next        = r_len;
    w_sup_next        = r_sup;
    w_miss_next       = r_miss;
    w_lock_next       = r_lock;
    w_pyld_data_next  = r_pyld_data;
    w_pyld_valid_next = 1'b0;
    w_fas_err_next    = 1'b0;
    w_len_err_next    = 1'b0;
    w_ovf_next        = 1'b0;
`ifdef DEMAP_BIP8_EN
    w_bip_next        = r_bip;
    w_bip_err_next    = 1'b0;
`endif
    if (i_frame_data_valid) begin
      if (i_frame_data_fas) begin
        // A FAS flag always restarts; mid-frame it abandons the frame in flight.
        w_cnt_next = 12'd1;
        if (r_state != ST_HUNT) begin
          w_fas_err_next = 1'b1;
          w_miss_next    = w_miss_inc;
          if (w_miss_hit) w_lock_next = 1'b0;
        end
      end else begin
        case (r_state)
          ST_FAS: begin
            w_cnt_next = w_fas_last ? 12'd0 : r_cnt + 12'd1;
            if (w_fas_last) begin
              if (w_fas_match) begin
                w_miss_next = 4'd0;
                w_lock_next = 1'b1;
              end else begin
                w_fas_err_next = 1'b1;
                w_miss_next    = w_miss_inc;
                if (w_miss_hit) w_lock_next = 1'b0;
              end
            end
          end
          ST_LEN: begin
            w_cnt_next = w_byte_done ? 12'd0 : r_cnt + 12'd1;
            if (w_byte_done) begin
              w_len_next     = w_byte;
              w_sup_next     = (w_byte > PYLD_B8);
              w_len_err_next = (w_byte > PYLD_B8);
`ifdef DEMAP_BIP8_EN
              w_bip_next     = 8'd0;
`endif
            end
          end
          ST_PYLD: begin
            w_cnt_next = w_pyld_last ? 12'd0 : r_cnt + 12'd1;
            if (w_byte_done) begin
`ifdef DEMAP_BIP8_EN
              w_bip_next = r_bip ^ w_byte;
`endif
              if (w_keep) begin
                if (i_fifo_full) begin
                  w_ovf_next = 1'b1;
                end else begin
                  w_pyld_valid_next = 1'b1;
                  w_pyld_data_next  = w_byte;
                end
              end
            end
          end
`ifdef DEMAP_BIP8_EN
          ST_BIP: begin
            w_cnt_next = w_byte_done ? 12'd0 : r_cnt + 12'd1;
            if (w_byte_done) w_bip_err_next = (w_byte != r_bip);
          end
`endif
          default: w_cnt_next = r_cnt;
        endcase
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt        <= 12'd0;
      r_sh         <= 16'd0;
      r_len        <= 8'd0;
      r_sup        <= 1'b0;
      r_miss       <= 4'd0;
      r_lock       <= 1'b0;
      r_pyld_data  <= 8'd0;
      r_pyld_valid <= 1'b0;
      r_fas_err    <= 1'b0;
      r_len_err    <= 1'b0;
      r_ovf        <= 1'b0;
`ifdef DEMAP_BIP8_EN
      r_bip        <= 8'd0;
      r_bip_err    <= 1'b0;
`endif
    end else begin
      r_cnt        <= w_cnt_next;
      if (i_frame_data_valid) r_sh <= w_sh_shift;
      r_len        <= w_len_next;
      r_sup        <= w_sup_next;
      r_miss       <= w_miss_next;
      r_lock       <= w_lock_next;
      r_pyld_data  <= w_pyld_data_next;
      r_pyld_valid <= w_pyld_valid_next;
      r_fas_err    <= w_fas_err_next;
      r_len_err    <= w_len_err_next;
      r_ovf        <= w_ovf_next;
`ifdef DEMAP_BIP8_EN
      r_bip        <= w_bip_next;
      r_bip_err    <= w_bip_err_next;
`endif
    end
  end

  assign o_pyld_data       = r_pyld_data;
  assign o_pyld_data_valid = r_pyld_valid;
  assign o_frame_lock      = r_lock;
  assign o_fas_err         = r_fas_err;
  assign o_len_err         = r_len_err;
  assign o_ovf             = r_ovf;
`ifdef DEMAP_BIP8_EN
  assign o_bip_err         = r_bip_err;
`else
  assign o_bip_err         = 1'b0;
`endif

endmodule

// File: tb/tb_demapper.sv
// Randomized bench for demapper: frames are built as byte arrays and expected per-bit outputs
// are derived from frame layout (field positions, LEN, FIFO-full flags, lock/miss counting).
module tb_demapper;

  localparam int          PB   = 16;
  localparam logic [15:0] FASP = 16'hF628;
  localparam int          LL   = 2;
`ifdef DEMAP_BIP8_EN
  localparam bit BIP = 1'b1;
`else
  localparam bit BIP = 1'b0;
`endif
  localparam int NBYTES = 3 + PB + (BIP ? 1 : 0);

  logic       clk = 1'b0;
  logic       rst, d, dv, dfas, full;
  logic [7:0] pyld_data;
  logic       pyld_valid, frame_lock, fas_err, len_err, ovf, bip_err;
  logic [4:0] pulses;

  always #5 clk = ~clk;

  demapper #(.PYLD_BYTES(PB), .FAS_PATTERN(FASP), .LOCK_LOSS(LL)) dut (
    .i_clk(clk), .i_rst(rst), .i_frame_data(d), .i_frame_data_valid(dv),
    .i_frame_data_fas(dfas), .o_pyld_data(pyld_data), .o_pyld_data_valid(pyld_valid),
    .i_fifo_full(full), .o_frame_lock(frame_lock), .o_fas_err(fas_err),
    .o_len_err(len_err), .o_ovf(ovf), .o_bip_err(bip_err)
  );

  assign pulses = {pyld_valid, fas_err, len_err, ovf, bip_err};

  int n_checks = 0;
  int n_errors = 0;
  int frame_no = 0;
  int gap_pct  = 0;

  // Reference state: frame-in-progress flag, miss count, lock.
  bit m_in_frame = 1'b0;
  int m_miss     = 0;
  bit m_lock     = 1'b0;

  logic [7:0] fb [NBYTES];
  bit         ff [PB];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (frame %0d, t=%0t)", tag, obs, exp, frame_no, $time);
    end
  endtask

  task automatic miss_inc();
    if (m_miss < LL) m_miss++;
    if (m_miss == LL) m_lock = 1'b0;
  endtask

  task automatic drive_bit(input logic b, input logic fas, input logic fnow,
                           input logic [4:0] ep, input logic [7:0] ed);
    int g = 0;
    while (g < 6 && $urandom_range(99) < gap_pct) begin
      @(negedge clk);
      dv = 1'b0; d = 1'($urandom); dfas = 1'($urandom); full = 1'($urandom);
      @(posedge clk); #1;
      chk("idle_pulses", pulses, 0);
      chk("idle_lock", frame_lock, m_lock);
      g++;
    end
    @(negedge clk);
    dv = 1'b1; d = b; dfas = fas; full = fnow;
    @(posedge clk); #1;
    chk("pulses", pulses, ep);
    if (ep[4]) chk("data", pyld_data, ed);
    chk("lock", frame_lock, m_lock);
  endtask

  task automatic make_frame(input logic [15:0] fw, input logic [7:0] len);
    fb[0] = fw[15:8];
    fb[1] = fw[7:0];
    fb[2] = len;
    for (int k = 0; k < NBYTES - 3; k++) fb[3 + k] = 8'($urandom);
    for (int k = 0; k < PB; k++) ff[k] = 1'b0;
  endtask

  task automatic seal();
    logic [7:0] x = 8'd0;
    for (int k = 0; k < PB; k++) x ^= fb[3 + k];
    if (BIP) fb[NBYTES - 1] = x;
  endtask

  // Sends nsend bits of the frame (negative = whole frame); expectations follow the frame layout.
  task automatic send_frame(input int nsend);
    int         nbits = 8 * NBYTES;
    logic [7:0] len   = fb[2];
    bit         fas_ok = ({fb[0], fb[1]} == FASP);
    logic [7:0] x = 8'd0;
    int         n_exp = 0;
    for (int k = 0; k < PB; k++) x ^= fb[3 + k];
    if (nsend < 0 || nsend > nbits) nsend = nbits;
    frame_no++;
    for (int i = 0; i < nsend; i++) begin
      logic [4:0] ep = 5'd0;
      logic [7:0] ed = 8'd0;
      logic       b  = fb[i / 8][7 - (i % 8)];
      logic       fnow = ($urandom_range(3) == 0);
      if (i == 0) begin
        if (m_in_frame) begin
          ep[3] = 1'b1;
          miss_inc();
        end
        m_in_frame = 1'b1;
      end else if (!m_in_frame) begin
        ep = 5'd0;
      end else if (i == 15) begin
        if (fas_ok) begin
          m_miss = 0;
          m_lock = 1'b1;
        end else begin
          ep[3] = 1'b1;
          miss_inc();
          m_in_frame = 1'b0;
        end
      end else if (i == 23) begin
        if (len > PB) ep[2] = 1'b1;
      end else if (i >= 24 && i < 24 + 8 * PB && (i % 8) == 7) begin
        int k = (i - 24) / 8;
        fnow = ff[k];
        if (len <= PB && k < int'(len)) begin
          if (fnow) ep[1] = 1'b1;
          else begin
            ep[4] = 1'b1;
            ed = fb[3 + k];
            n_exp++;
          end
        end
        if (i == 24 + 8 * PB - 1 && !BIP) m_in_frame = 1'b0;
      end else if (BIP && i == nbits - 1) begin
        ep[0] = (fb[NBYTES - 1] != x);
        m_in_frame = 1'b0;
      end
      drive_bit(b, (i == 0), fnow, ep, ed);
    end
    $display("frame %0d: fas=%h len=%0d bits=%0d strobes_expected=%0d lock=%0d",
             frame_no, {fb[0], fb[1]}, len, nsend, n_exp, m_lock);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; dv = 1'b0; dfas = 1'b0; d = 1'b0; full = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_in_frame = 1'b0;
    m_miss = 0;
    m_lock = 1'b0;
    chk("reset_outputs", {pyld_data, pulses, frame_lock}, 0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; d = 1'b0; dv = 1'b0; dfas = 1'b0; full = 1'b0;
    do_reset();

    // Basic decode: LEN=3, payload 11 22 33 plus padding.
    make_frame(FASP, 8'd3);
    fb[3] = 8'h11; fb[4] = 8'h22; fb[5] = 8'h33;
    seal();
    send_frame(-1);
    chk("lock_after_good", frame_lock, 1);

    // Two bad FAS words drop lock on the second.
    make_frame(16'hF629, 8'd3); seal(); send_frame(-1);
    chk("lock_after_one_bad", frame_lock, 1);
    make_frame(16'hF629, 8'd3); seal(); send_frame(-1);
    chk("lock_after_two_bad", frame_lock, 0);

    // Oversized LEN, then a good frame; boundary LEN=PB and LEN=0.
    make_frame(FASP, 8'(PB + 1)); seal(); send_frame(-1);
    make_frame(FASP, 8'd5); seal(); send_frame(-1);
    make_frame(FASP, 8'(PB)); seal(); send_frame(-1);
    make_frame(FASP, 8'd0); seal(); send_frame(-1);

    // FIFO full on the 2nd byte of a LEN=4 frame.
    make_frame(FASP, 8'd4); ff[1] = 1'b1; seal(); send_frame(-1);

    // FAS flag at bit 40 of a frame, then a complete frame.
    make_frame(FASP, 8'd6); seal(); send_frame(40);
    make_frame(FASP, 8'd6); seal(); send_frame(-1);

    // BIP: correct trailer, then a payload bit flipped after sealing.
    make_frame(FASP, 8'd8); seal(); send_frame(-1);
    make_frame(FASP, 8'd8); seal(); fb[5] ^= 8'h10; send_frame(-1);

    // Random frames with valid gaps.
    gap_pct = 30;
    for (int f = 0; f < 24; f++) begin
      int         r = $urandom_range(9);
      logic [7:0] len;
      logic [15:0] fw;
      len = (r == 0) ? 8'(PB + 1 + $urandom_range(20)) : 8'($urandom_range(PB));
      fw  = (r == 1) ? (FASP ^ 16'(1 << $urandom_range(15))) : FASP;
      make_frame(fw, len);
      for (int k = 0; k < PB; k++) ff[k] = ($urandom_range(5) == 0);
      seal();
      if (r == 2) fb[3 + $urandom_range(PB - 1)] ^= 8'h80;
      send_frame((r == 3) ? int'($urandom_range(8 * NBYTES - 1, 1)) : -1);
    end

    // Reset mid-payload: partial byte discarded, next frame starts cleanly from HUNT.
    gap_pct = 0;
    make_frame(FASP, 8'd4); seal(); send_frame(24 + 8 + 4);
    do_reset();
    make_frame(FASP, 8'd4); seal(); send_frame(-1);
    chk("lock_after_reset_frame", frame_lock, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
